// File: rtl/tlp_tx_mux.sv
// tlp_tx_mux: transmit-side TLP serializer for the PCIe transaction layer.
// Pulls 128-bit headers and DATA_WIDTH payload beats from two show-ahead
// header/payload FIFO pairs (CPL = read completions, REQ = device-initiated
// requests). It arbitrates round-robin at TLP boundaries and emits one framed
// stream (valid/ready/last) through a single output register stage.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpl_hdr_* / cpl_pay_*     CPL header/payload FIFO (empty, data, last, rden)
//   req_hdr_* / req_pay_*     REQ header/payload FIFO (empty, data, last, rden)
//   tlp_out_valid/data/last   framed output beat (header in data[127:0])
//   tlp_out_ready             link layer accepts the presented beat
//   busy                      a TLP is in progress or a beat is still held
//   protocol_err              sticky: source last flag disagreed with Length
module tlp_tx_mux #(
  parameter int DATA_WIDTH = 256,
  parameter int LEN_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpl_hdr_empty,
  input  logic [127:0]          cpl_hdr_data,
  output logic                  cpl_hdr_rden,
  input  logic                  cpl_pay_empty,
  input  logic [DATA_WIDTH-1:0] cpl_pay_data,
  input  logic                  cpl_pay_last,
  output logic                  cpl_pay_rden,
  input  logic                  req_hdr_empty,
  input  logic [127:0]          req_hdr_data,
  output logic                  req_hdr_rden,
  input  logic                  req_pay_empty,
  input  logic [DATA_WIDTH-1:0] req_pay_data,
  input  logic                  req_pay_last,
  output logic                  req_pay_rden,
  output logic                  tlp_out_valid,
  output logic [DATA_WIDTH-1:0] tlp_out_data,
  output logic                  tlp_out_last,
  input  logic                  tlp_out_ready,
  output logic                  busy,
  output logic                  protocol_err
);

  localparam int DW_PER_BEAT = DATA_WIDTH / 32;
  // Sized for the worst case: 1024 DW on a 128-bit datapath = 256 beats.
  localparam int CNT_W = $clog2(((1 << LEN_W) * 32) / 128 + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PAY  = 1'b1
  } state_t;

  // Payload beat count for a Length field; Length 0 encodes the maximum.
  function automatic logic [CNT_W-1:0] calc_beats(input logic [LEN_W-1:0] len);
    logic [31:0] dw_cnt;
    logic [31:0] beat_cnt;
    if (len == {LEN_W{1'b0}}) begin
      dw_cnt = 32'd1 << LEN_W;
    end else begin
      dw_cnt = 32'(len);
    end
    beat_cnt = (dw_cnt + 32'(DW_PER_BEAT) - 32'd1) / 32'(DW_PER_BEAT);
    return beat_cnt[CNT_W-1:0];
  endfunction

  state_t                state_r, state_nx_s;
  logic                  rr_ptr_r, rr_ptr_nx_s;       // 0 = CPL next, 1 = REQ next
  logic                  grant_r, grant_nx_s;         // 0 = CPL owns TLP, 1 = REQ
  logic [CNT_W-1:0]      beats_left_r, beats_left_nx_s;
  logic                  protocol_err_r, protocol_err_nx_s;
  logic                  out_valid_r, out_valid_nx_s;
  logic [DATA_WIDTH-1:0] out_data_r, out_data_nx_s;
  logic                  out_last_r, out_last_nx_s;

  logic                  adv_s;
  logic                  hdr_any_s;
  logic                  grant_req_s;
  logic [127:0]          sel_hdr_s;
  logic                  sel_has_data_s;
  logic                  sel_pay_empty_s;
  logic [DATA_WIDTH-1:0] sel_pay_data_s;
  logic                  sel_pay_last_s;
  logic                  last_beat_s;
  logic                  hdr_take_s;
  logic                  pay_take_s;

  // Output register may load whenever it is empty or being drained this cycle.
  assign adv_s     = !out_valid_r || tlp_out_ready;
  assign hdr_any_s = !cpl_hdr_empty || !req_hdr_empty;
  // With both sources pending rr_ptr decides; otherwise the lone pending one.
  assign grant_req_s = (!cpl_hdr_empty && !req_hdr_empty) ? rr_ptr_r : !req_hdr_empty;
  assign sel_hdr_s      = grant_req_s ? req_hdr_data : cpl_hdr_data;
  assign sel_has_data_s = sel_hdr_s[30];
  // Payload side follows the latched grant, never the live arbitration.
  assign sel_pay_empty_s = grant_r ? req_pay_empty : cpl_pay_empty;
  assign sel_pay_data_s  = grant_r ? req_pay_data  : cpl_pay_data;
  assign sel_pay_last_s  = grant_r ? req_pay_last  : cpl_pay_last;
  assign last_beat_s     = (beats_left_r == CNT_ONE);

  assign cpl_hdr_rden = hdr_take_s && !grant_req_s;
  assign req_hdr_rden = hdr_take_s &&  grant_req_s;
  assign cpl_pay_rden = pay_take_s && !grant_r;
  assign req_pay_rden = pay_take_s &&  grant_r;

  assign tlp_out_valid = out_valid_r;
  assign tlp_out_data  = out_data_r;
  assign tlp_out_last  = out_last_r;
  assign busy          = (state_r != ST_IDLE) || out_valid_r;
  assign protocol_err  = protocol_err_r;

  // Next-state, pop strobes and next output-register contents.
  always_comb begin
    state_nx_s        = state_r;
    rr_ptr_nx_s       = rr_ptr_r;
    grant_nx_s        = grant_r;
    beats_left_nx_s   = beats_left_r;
    protocol_err_nx_s = protocol_err_r;
    out_data_nx_s     = out_data_r;
    out_last_nx_s     = out_last_r;
    hdr_take_s        = 1'b0;
    pay_take_s        = 1'b0;
    // An accepted (or absent) beat not replaced this cycle leaves a bubble.
    if (adv_s) begin
      out_valid_nx_s = 1'b0;
    end else begin
      out_valid_nx_s = out_valid_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (adv_s && !rst && hdr_any_s) begin
          hdr_take_s              = 1'b1;
          out_valid_nx_s          = 1'b1;
          out_data_nx_s           = {DATA_WIDTH{1'b0}};
          out_data_nx_s[127:0]    = sel_hdr_s;
          out_last_nx_s           = !sel_has_data_s;
          grant_nx_s              = grant_req_s;
          beats_left_nx_s         = calc_beats(sel_hdr_s[LEN_W-1:0]);
          rr_ptr_nx_s             = !grant_req_s;
          if (sel_has_data_s) begin
            state_nx_s = ST_PAY;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PAY: begin
        if (adv_s && !rst && !sel_pay_empty_s) begin
          pay_take_s      = 1'b1;
          out_valid_nx_s  = 1'b1;
          out_data_nx_s   = sel_pay_data_s;
          out_last_nx_s   = last_beat_s;
          beats_left_nx_s = beats_left_r - CNT_ONE;
          // Framing trusts the Length-derived count; the source flag only flags.
          if (sel_pay_last_s != last_beat_s) begin
            protocol_err_nx_s = 1'b1;
          end else begin
            protocol_err_nx_s = protocol_err_r;
          end
          if (last_beat_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_PAY;
          end
        end else begin
          state_nx_s = ST_PAY;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, arbitration, counter, error flag and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      rr_ptr_r       <= 1'b0;
      grant_r        <= 1'b0;
      beats_left_r   <= {CNT_W{1'b0}};
      protocol_err_r <= 1'b0;
      out_valid_r    <= 1'b0;
      out_data_r     <= {DATA_WIDTH{1'b0}};
      out_last_r     <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      rr_ptr_r       <= rr_ptr_nx_s;
      grant_r        <= grant_nx_s;
      beats_left_r   <= beats_left_nx_s;
      protocol_err_r <= protocol_err_nx_s;
      out_valid_r    <= out_valid_nx_s;
      out_data_r     <= out_data_nx_s;
      out_last_r     <= out_last_nx_s;
    end
  end

endmodule

// File: tb/tb_tlp_tx_mux.sv
// tb_tlp_tx_mux: scoreboard bench for tlp_tx_mux. Stimulus pushes TLPs into
// bench-side show-ahead FIFO models and the expected output beats into a
// queue; a monitor pops and compares every beat the DUT hands over.
module tb_tlp_tx_mux;

  localparam int DW = 256;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          cpl_hdr_empty, cpl_hdr_rden, cpl_pay_empty, cpl_pay_last, cpl_pay_rden;
  logic [127:0]  cpl_hdr_data;
  logic [DW-1:0] cpl_pay_data;
  logic          req_hdr_empty, req_hdr_rden, req_pay_empty, req_pay_last, req_pay_rden;
  logic [127:0]  req_hdr_data;
  logic [DW-1:0] req_pay_data;
  logic          tlp_out_valid, tlp_out_last, tlp_out_ready, busy, protocol_err;
  logic [DW-1:0] tlp_out_data;

  logic [127:0] cpl_hdr_q[$];
  logic [127:0] req_hdr_q[$];
  beat_t        cpl_pay_q[$];
  beat_t        req_pay_q[$];
  beat_t        exp_q[$];
  int           mon_cyc[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int cpl_hdr_pops = 0, cpl_pay_pops = 0, req_hdr_pops = 0, req_pay_pops = 0;
  int cpl_hdr_pop_cyc = 0, req_hdr_pop_cyc = 0;
  int base_a, base_b, n_wait;

  tlp_tx_mux #(.DATA_WIDTH(DW), .LEN_W(10)) dut (
    .clk(clk), .rst(rst),
    .cpl_hdr_empty(cpl_hdr_empty), .cpl_hdr_data(cpl_hdr_data), .cpl_hdr_rden(cpl_hdr_rden),
    .cpl_pay_empty(cpl_pay_empty), .cpl_pay_data(cpl_pay_data), .cpl_pay_last(cpl_pay_last),
    .cpl_pay_rden(cpl_pay_rden),
    .req_hdr_empty(req_hdr_empty), .req_hdr_data(req_hdr_data), .req_hdr_rden(req_hdr_rden),
    .req_pay_empty(req_pay_empty), .req_pay_data(req_pay_data), .req_pay_last(req_pay_last),
    .req_pay_rden(req_pay_rden),
    .tlp_out_valid(tlp_out_valid), .tlp_out_data(tlp_out_data), .tlp_out_last(tlp_out_last),
    .tlp_out_ready(tlp_out_ready), .busy(busy), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [127:0] mk_hdr(input logic [31:0] tag, input logic has_data,
                                          input logic [9:0] len);
    return {tag, 32'hA5A50000 ^ tag, ~tag, 1'b0, has_data, 20'h00000, len};
  endfunction

  function automatic logic [DW-1:0] mk_pay(input logic [31:0] k);
    logic [31:0] w;
    w = 32'hC0DE0000 + k;
    return {8{w}};
  endfunction

  // Queue one TLP in the source FIFO models and its expected output beats.
  // early >= 0 puts the source last flag on that payload index instead.
  task automatic send_tlp(input bit is_req, input logic [127:0] h, input int nbeats,
                          input int early, input int tag_base);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = mk_pay(32'(tag_base + i));
      b.last = (early >= 0) ? (i == early) : (i == nbeats - 1);
      if (is_req) req_pay_q.push_back(b);
      else        cpl_pay_q.push_back(b);
    end
    if (is_req) req_hdr_q.push_back(h);
    else        cpl_hdr_q.push_back(h);
    b.data = {128'd0, h};
    b.last = !h[30];
    exp_q.push_back(b);
    for (int i = 0; i < nbeats; i++) begin
      b.data = mk_pay(32'(tag_base + i));
      b.last = (i == nbeats - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_fifos();
    cpl_hdr_empty = (cpl_hdr_q.size() == 0);
    cpl_hdr_data  = cpl_hdr_empty ? 128'd0 : cpl_hdr_q[0];
    req_hdr_empty = (req_hdr_q.size() == 0);
    req_hdr_data  = req_hdr_empty ? 128'd0 : req_hdr_q[0];
    cpl_pay_empty = (cpl_pay_q.size() == 0);
    cpl_pay_data  = cpl_pay_empty ? {DW{1'b0}} : cpl_pay_q[0].data;
    cpl_pay_last  = cpl_pay_empty ? 1'b0 : cpl_pay_q[0].last;
    req_pay_empty = (req_pay_q.size() == 0);
    req_pay_data  = req_pay_empty ? {DW{1'b0}} : req_pay_q[0].data;
    req_pay_last  = req_pay_empty ? 1'b0 : req_pay_q[0].last;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cpl_hdr_q.size() != 0 || req_hdr_q.size() != 0 ||
            cpl_pay_q.size() != 0 || req_pay_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_timeout"}, int'(n >= budget), 0);
  endtask

  // FIFO models: sample pop strobes mid-cycle, retire entries after the edge.
  initial begin
    bit p_ch, p_cp, p_rh, p_rp;
    logic [127:0] hd;
    beat_t bd;
    drive_fifos();
    forever begin
      @(negedge clk);
      p_ch = cpl_hdr_rden;
      p_cp = cpl_pay_rden;
      p_rh = req_hdr_rden;
      p_rp = req_pay_rden;
      if (rst) chk("rden_during_rst", int'({p_ch, p_cp, p_rh, p_rp}), 0);
      if (p_ch) begin chk("pop_empty_cpl_hdr", int'(cpl_hdr_empty), 0); cpl_hdr_pop_cyc = cyc; end
      if (p_cp) chk("pop_empty_cpl_pay", int'(cpl_pay_empty), 0);
      if (p_rh) begin chk("pop_empty_req_hdr", int'(req_hdr_empty), 0); req_hdr_pop_cyc = cyc; end
      if (p_rp) chk("pop_empty_req_pay", int'(req_pay_empty), 0);
      @(posedge clk);
      #1;
      if (p_ch && cpl_hdr_q.size() != 0) begin hd = cpl_hdr_q.pop_front(); cpl_hdr_pops++; end
      if (p_cp && cpl_pay_q.size() != 0) begin bd = cpl_pay_q.pop_front(); cpl_pay_pops++; end
      if (p_rh && req_hdr_q.size() != 0) begin hd = req_hdr_q.pop_front(); req_hdr_pops++; end
      if (p_rp && req_pay_q.size() != 0) begin bd = req_pay_q.pop_front(); req_pay_pops++; end
      drive_fifos();
    end
  end

  // Monitor: every beat handed over (valid && ready) is matched to the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && tlp_out_valid && tlp_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chkw("beat_data", tlp_out_data, e.data);
          chk("beat_last", int'(tlp_out_last), int'(e.last));
          mon_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tlp_out_ready = 1'b1;
    // Round-robin preload while in reset: three header-only TLPs per source.
    for (int i = 0; i < 3; i++) begin
      send_tlp(1'b0, mk_hdr(32'h100 + 32'(i), 1'b0, 10'd1), 0, -1, 0);
      send_tlp(1'b1, mk_hdr(32'h200 + 32'(i), 1'b0, 10'd1), 0, -1, 0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(tlp_out_valid), 0);
    chk("rst_last", int'(tlp_out_last), 0);
    chkw("rst_data", tlp_out_data, {DW{1'b0}});
    chk("rst_busy", int'(busy), 0);
    chk("rst_protocol_err", int'(protocol_err), 0);
    @(posedge clk);
    #1;
    mon_cyc.delete();
    rst = 1'b0;
    drain("rr", 50);
    chk("rr_beats", mon_cyc.size(), 6);
    if (mon_cyc.size() == 6) chk("rr_one_per_cycle", mon_cyc[5] - mon_cyc[0], 5);

    // REQ MRd, header only.
    base_a = req_hdr_pops;
    mon_cyc.delete();
    send_tlp(1'b1, mk_hdr(32'h1, 1'b0, 10'd1), 0, -1, 0);
    drain("mrd", 50);
    chk("mrd_hdr_pops", req_hdr_pops - base_a, 1);
    chk("mrd_latency", mon_cyc[$] - req_hdr_pop_cyc, 1);
    chk("mrd_idle", int'(busy), 0);

    // CPL CplD, len 16 -> two 256-bit beats.
    base_a = cpl_pay_pops;
    send_tlp(1'b0, mk_hdr(32'h2, 1'b1, 10'd16), 2, -1, 32'h20);
    drain("cpld16", 50);
    chk("cpld16_pay_pops", cpl_pay_pops - base_a, 2);
    chk("cpld16_protocol_err", int'(protocol_err), 0);

    // Backpressure: len 32 (4 beats), ready low for 5 cycles mid-payload.
    base_a = cpl_pay_pops;
    send_tlp(1'b0, mk_hdr(32'h3, 1'b1, 10'd32), 4, -1, 32'h30);
    n_wait = 0;
    while (exp_q.size() > 3 && n_wait < 50) begin @(posedge clk); #1; n_wait++; end
    chk("stall_reach_timeout", int'(n_wait >= 50), 0);
    tlp_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", int'(tlp_out_valid), 1);
      if (exp_q.size() != 0) begin
        chkw("stall_data", tlp_out_data, exp_q[0].data);
        chk("stall_last", int'(tlp_out_last), int'(exp_q[0].last));
      end
      chk("stall_no_pop", int'({cpl_hdr_rden, cpl_pay_rden, req_hdr_rden, req_pay_rden}), 0);
    end
    @(posedge clk);
    #1;
    tlp_out_ready = 1'b1;
    drain("stall", 50);
    chk("stall_pay_pops", cpl_pay_pops - base_a, 4);

    // len 0 encodes 1024 DW -> 128 payload beats, on REQ.
    base_b = req_pay_pops;
    send_tlp(1'b1, mk_hdr(32'h4, 1'b1, 10'd0), 128, -1, 32'h400);
    drain("len0", 400);
    chk("len0_pay_pops", req_pay_pops - base_b, 128);
    chk("len0_protocol_err", int'(protocol_err), 0);

    // Source last flag early on the first beat of a 2-beat TLP.
    send_tlp(1'b0, mk_hdr(32'h5, 1'b1, 10'd16), 2, 0, 32'h50);
    drain("early_last", 50);
    chk("early_last_protocol_err", int'(protocol_err), 1);

    // Reset while PAY waits for its final beat (beats_left == 1).
    begin
      beat_t b;
      cpl_pay_q.push_back('{data: mk_pay(32'h60), last: 1'b0});
      cpl_hdr_q.push_back(mk_hdr(32'h6, 1'b1, 10'd16));
      b.data = {128'd0, mk_hdr(32'h6, 1'b1, 10'd16)};
      b.last = 1'b0;
      exp_q.push_back(b);
      b.data = mk_pay(32'h60);
      exp_q.push_back(b);
    end
    n_wait = 0;
    while (exp_q.size() != 0 && n_wait < 50) begin @(posedge clk); #1; n_wait++; end
    chk("rstpay_reach_timeout", int'(n_wait >= 50), 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("rstpay_busy_before", int'(busy), 1);
    rst = 1'b1;
    cpl_pay_q.push_back('{data: mk_pay(32'h61), last: 1'b1});
    @(posedge clk);
    @(negedge clk);
    chk("rstpay_valid", int'(tlp_out_valid), 0);
    chk("rstpay_busy", int'(busy), 0);
    chk("rstpay_protocol_err", int'(protocol_err), 0);
    @(posedge clk);
    #1;
    cpl_pay_q.delete();
    rst = 1'b0;
    base_a = req_hdr_pops;
    send_tlp(1'b1, mk_hdr(32'h7, 1'b0, 10'd1), 0, -1, 0);
    drain("after_rst", 50);
    chk("after_rst_hdr_pops", req_hdr_pops - base_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
